ats_cmd_frontend: RTL and testbench
===================================

Name: ats_cmd_frontend

Overview:
Parametrised multi-client instruction capture front-end for the ATS timer core, generalising the two-client (A/B) 16-bit split-word request protocol to NUM_CLIENTS ports of WORD_W bits. Each client delivers a 2-word instruction, high word first, low word next. Staggered requests, where req is held across consecutive cycles, are supported per client. Completed instructions are round-robin arbitrated into an output FIFO tagged with the client ID; the core pops them via valid/ready.

Parameters:
NUM_CLIENTS, 2, number of client ctrl ports (1..8)
WORD_W, 16, width of one instruction word (>= 8)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2)
OPC_W, 3, opcode field width at the top of the high word; opcode 0 = Nop

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  request strobe shared by all clients
ctrl  in  NUM_CLIENTS*WORD_W  client words; client i = ctrl[i*WORD_W +: WORD_W]
ready  out  1  front-end can accept a new instruction
out_valid  out  1  FIFO head valid
out_ready  in  1  core accepts FIFO head
out_client  out  max(1,$clog2(NUM_CLIENTS))  client ID of FIFO head
out_instr  out  2*WORD_W  {hi, lo} instruction at FIFO head
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  NUM_CLIENTS  sticky per-client drop flag
clr_overflow  in  1  synchronous clear of all overflow bits

Behaviour:
- Reset (async, active-high) clears all state:
  - out_valid=0, out_client=0, out_instr=0, fifo_count=0, overflow=0.
  - Round-robin pointer resets to client 0.
  - All client FSMs go to IDLE. All holding registers are emptied.
  - ready=1 while reset is asserted and afterwards until the first capture.
- Per-client FSM:
  - IDLE: if req=1 and the top OPC_W bits of the client word are nonzero, latch the hi word and go to WAIT_LO. Otherwise stay in IDLE; a Nop is ignored.
  - WAIT_LO: latch the lo word unconditionally, regardless of req. Go to IDLE.
  - If the client's holding register is empty, write {hi, lo} to it and set hold_valid.
  - If hold_valid is already set, drop the new instruction, keep the old one, and set overflow[i].
- Staggered requests: while client i is in WAIT_LO, its word is always its lo word, even if req=1. req=1 in that cycle only starts captures for clients currently in IDLE.
- Arbiter:
  - At most one holding register is transferred to the FIFO per cycle.
  - Grant goes to the first hold_valid client at or after the RR pointer. The pointer then moves to grant+1, modulo NUM_CLIENTS.
  - A transfer requires FIFO not full, or a pop in the same cycle.
  - A granted holding register is cleared in the same cycle.
- FIFO:
  - Registered, not fall-through. Order is preserved.
  - Pop happens when out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_client and out_instr hold their value while out_valid=0.
- Latency: req with hi in cycle T, lo in T+1, holding valid in T+2, FIFO write at the end of T+2, out_valid=1 in T+3. Minimum latency is 3 cycles.
- ready: combinational. ready=1 when every holding register is empty and fifo_count < FIFO_DEPTH. Clients must not start a request while ready=0. If they do, the overflow rules still apply and there is no corruption.
- overflow: sticky. Cleared when clr_overflow=1. A set and clr_overflow in the same cycle: the set wins.
- Reset mid-operation: partial captures are discarded. A lo word arriving after reset deasserts, with req=0, is ignored.

Test Plan:
1. Single request, A=0x2000_0000 (set_clock, clk0, 1X), B=0: req in T -> out_valid in T+3, out_client=0, out_instr=0x20000000, fifo_count 1 -> 0 after pop.
2. Simultaneous request, A=0x2000_0000, B=0x2240_0000: -> entry (0, 0x20000000) in T+3, then (1, 0x22400000) in T+4. The RR pointer then favours client 0.
3. Staggered request:
   - C1: req=1, A=0x2000, B=0x0000.
   - C2: req=1, A=0x0000, B=0x2240.
   - C3: req=0, A=0x0000, B=0x0000.
   - Required: A entry 0x20000000 in C1+3, then B entry 0x22400000. A's lo word in C2 is not treated as a new request.
4. Backpressure, out_ready=0, FIFO_DEPTH=4: A issues 6 back-to-back instructions 0xA000_0001..0xA000_0006 (ready ignored) -> fifo_count=4, ready=0, fifth held in holding register, sixth dropped with overflow[0]=1. Then out_ready=1 -> 0xA0000001..0xA0000005 delivered in order. clr_overflow -> overflow=0.
5. Nop filter: req=1 with A=B=0x0000, then 0x1FFF (opcode 000) -> no FIFO entries, ready stays 1.
6. Async reset mid-operation: reset asserted between A hi 0x6000 and lo 0x0010 -> all outputs return to reset values immediately. The later lo word with req=0 produces no entry.

Source files
------------

// File: rtl/ats_cmd_frontend.sv
// Multi-client split-word instruction capture front-end for the ATS timer core.
// Each client builds a {hi, lo} instruction in a holding register; a round-robin arbiter feeds a tagged output FIFO.
module ats_cmd_frontend #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned OPC_W       = 3
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               req,
  input  logic [NUM_CLIENTS*WORD_W-1:0]                      ctrl,
  output logic                                               ready,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [((NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1)-1:0] out_client,
  output logic [2*WORD_W-1:0]                                out_instr,
  output logic [$clog2(FIFO_DEPTH):0]                        fifo_count,
  output logic [NUM_CLIENTS-1:0]                             overflow,
  input  logic                                               clr_overflow
);

  localparam int unsigned CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = 2 * WORD_W;
  localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT_LO} state_e;

  state_e                 state_q      [NUM_CLIENTS];
  state_e                 state_d      [NUM_CLIENTS];
  logic [WORD_W-1:0]      hi_q         [NUM_CLIENTS];
  logic [WORD_W-1:0]      hi_d         [NUM_CLIENTS];
  logic [IW-1:0]          hold_q       [NUM_CLIENTS];
  logic [IW-1:0]          hold_d       [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] hold_valid_q, hold_valid_d;
  logic [NUM_CLIENTS-1:0] ovf_q, ovf_d;
  logic [CW-1:0]          rr_q, rr_d;
  logic [IW-1:0]          mem_instr_q  [FIFO_DEPTH];
  logic [IW-1:0]          mem_instr_d  [FIFO_DEPTH];
  logic [CW-1:0]          mem_client_q [FIFO_DEPTH];
  logic [CW-1:0]          mem_client_d [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic                   grant_vld, push, pop;
  logic [CW-1:0]          grant_idx;
  logic [PW-1:0]          head_idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (!grant_vld && hold_valid_q[(32'(rr_q) + k) % NUM_CLIENTS]) begin
        grant_vld = 1'b1;
        grant_idx = CW'((32'(rr_q) + k) % NUM_CLIENTS);
      end
    end
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = grant_vld && ((count_q < FULL) || pop);
  assign ready     = (hold_valid_q == '0) && (count_q < FULL);

  always_comb begin
    hold_valid_d = hold_valid_q;
    ovf_d        = clr_overflow ? '0 : ovf_q;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      state_d[i] = state_q[i];
      hi_d[i]    = hi_q[i];
      hold_d[i]  = hold_q[i];
      if (push && (grant_idx == CW'(i))) hold_valid_d[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (req && (ctrl[i*WORD_W+WORD_W-1 -: OPC_W] != '0)) begin
            hi_d[i]    = ctrl[i*WORD_W +: WORD_W];
            state_d[i] = S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          state_d[i] = S_IDLE;
          if (hold_valid_q[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            hold_d[i]       = {hi_q[i], ctrl[i*WORD_W +: WORD_W]};
            hold_valid_d[i] = 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rr_d     = push ? CW'((32'(grant_idx) + 1) % NUM_CLIENTS) : rr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
      mem_instr_d[j]  = mem_instr_q[j];
      mem_client_d[j] = mem_client_q[j];
    end
    if (push) begin
      mem_instr_d[wr_ptr_q]  = hold_q[grant_idx];
      mem_client_d[wr_ptr_q] = grant_idx;
    end
  end

  // When empty, show the slot just popped (never overwritten until the next push)
  // so the outputs hold their last value without a separate output register.
  assign head_idx   = (count_q == '0) ? rd_ptr_q - 1'b1 : rd_ptr_q;
  assign out_instr  = mem_instr_q[head_idx];
  assign out_client = mem_client_q[head_idx];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        state_q[i] <= S_IDLE;
        hi_q[i]    <= '0;
        hold_q[i]  <= '0;
      end
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        mem_instr_q[j]  <= '0;
        mem_client_q[j] <= '0;
      end
      hold_valid_q <= '0;
      ovf_q        <= '0;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      hold_q       <= hold_d;
      mem_instr_q  <= mem_instr_d;
      mem_client_q <= mem_client_d;
      hold_valid_q <= hold_valid_d;
      ovf_q        <= ovf_d;
      rr_q         <= rr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_ats_cmd_frontend.sv
// Scoreboard bench for ats_cmd_frontend: stimulus pushes expected {client, instr} entries,
// a negedge monitor pops and compares each FIFO head the core accepts.
module tb_ats_cmd_frontend;

  logic        clk = 1'b0;
  logic        reset, req, out_ready, clr_overflow;
  logic [31:0] ctrl;
  logic        ready, out_valid, out_client;
  logic [31:0] out_instr;
  logic [2:0]  fifo_count;
  logic [1:0]  overflow;

  int          total = 0;
  int          bad   = 0;
  logic [32:0] exp_q [$];

  ats_cmd_frontend #(.NUM_CLIENTS(2), .WORD_W(16), .FIFO_DEPTH(4), .OPC_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .ctrl(ctrl), .ready(ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_client(out_client),
    .out_instr(out_instr), .fifo_count(fifo_count), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry: got %0h expected none", {out_client, out_instr});
      end else begin
        chk("fifo_head", {31'd0, out_client, out_instr}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b);
    req  = r;
    ctrl = {b, a};
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int maxc);
    for (int i = 0; i < maxc && (exp_q.size() != 0 || out_valid); i++) cyc();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; ctrl = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_client", out_client, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // single request, 3-cycle latency, hold after pop
    drive(1, 16'h2000, 16'h0000); exp_q.push_back({1'b0, 32'h2000_0000});
    mid(); chk("t1_lat0", out_valid, 0); cyc();
    drive(0, 16'h0000, 16'h0000);
    mid(); chk("t1_lat1", out_valid, 0); cyc();
    mid(); chk("t1_lat2", out_valid, 0); cyc();
    mid(); chk("t1_valid", out_valid, 1); chk("t1_client", out_client, 0);
    chk("t1_instr", out_instr, 32'h2000_0000); chk("t1_count", fifo_count, 1); cyc();
    out_ready = 1'b1;
    mid(); cyc();
    mid(); chk("t1_count_after", fifo_count, 0); chk("t1_valid_after", out_valid, 0);
    chk("t1_instr_hold", out_instr, 32'h2000_0000); cyc();

    // simultaneous request from both clients
    pulse_reset();
    drive(1, 16'h2000, 16'h2240);
    exp_q.push_back({1'b0, 32'h2000_0000});
    exp_q.push_back({1'b1, 32'h2240_0000});
    mid(); cyc();
    drive(0, 16'h0000, 16'h0000);
    mid(); cyc();
    mid(); cyc();
    mid(); chk("t2_first_client", out_client, 0); chk("t2_first_valid", out_valid, 1); cyc();
    mid(); chk("t2_second_client", out_client, 1); chk("t2_second_instr", out_instr, 32'h2240_0000); cyc();
    mid(); chk("t2_empty", out_valid, 0); cyc();

    // staggered request: A's lo word overlaps B's hi word
    drive(1, 16'h2000, 16'h0000); exp_q.push_back({1'b0, 32'h2000_0000});
    mid(); cyc();
    drive(1, 16'h0000, 16'h2240); exp_q.push_back({1'b1, 32'h2240_0000});
    mid(); cyc();
    drive(0, 16'h0000, 16'h0000);
    mid(); cyc();
    mid(); chk("t3_a_client", out_client, 0); chk("t3_a_valid", out_valid, 1); cyc();
    mid(); chk("t3_b_client", out_client, 1); chk("t3_b_instr", out_instr, 32'h2240_0000); cyc();
    drain("t3_drain", 10);

    // backpressure: fill FIFO, hold fifth, drop sixth
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1, 16'hA000, 16'h0000); mid(); cyc();
      drive(0, 16'(k), 16'h0000); mid(); cyc();
      if (k <= 5) exp_q.push_back({1'b0, 32'hA000_0000 | 32'(k)});
    end
    drive(0, 16'h0000, 16'h0000);
    mid(); cyc();
    mid(); chk("t4_count_full", fifo_count, 4); chk("t4_ready", ready, 0);
    chk("t4_ovf", overflow, 2'b01); chk("t4_head", out_instr, 32'hA000_0001); cyc();
    out_ready = 1'b1;
    drain("t4_drain", 20);
    chk("t4_count_empty", fifo_count, 0);
    chk("t4_ovf_sticky", overflow, 2'b01);
    clr_overflow = 1'b1; mid(); cyc();
    clr_overflow = 1'b0; mid(); chk("t4_ovf_clr", overflow, 0); cyc();

    // Nop filter
    drive(1, 16'h0000, 16'h0000); mid(); chk("t5_ready0", ready, 1); cyc();
    drive(1, 16'h1FFF, 16'h1FFF); mid(); chk("t5_ready1", ready, 1); cyc();
    drive(0, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      mid(); chk("t5_count", fifo_count, 0); chk("t5_valid", out_valid, 0); chk("t5_ready", ready, 1); cyc();
    end

    // async reset mid-operation, with one entry already queued
    out_ready = 1'b0;
    drive(1, 16'h4000, 16'h0000); mid(); cyc();
    drive(0, 16'h0001, 16'h0000); mid(); cyc();
    drive(0, 16'h0000, 16'h0000); mid(); cyc();
    mid(); chk("t6_pre_valid", out_valid, 1); chk("t6_pre_instr", out_instr, 32'h4000_0001); cyc();
    drive(1, 16'h6000, 16'h0000); mid(); cyc();
    drive(0, 16'h0000, 16'h0000);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_instr", out_instr, 0);
    chk("t6_rst_client", out_client, 0);
    chk("t6_rst_ready", ready, 1);
    chk("t6_rst_ovf", overflow, 0);
    cyc();
    reset = 1'b0;
    drive(0, 16'h0010, 16'h0000); mid(); cyc();
    out_ready = 1'b1;
    drive(0, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      mid(); chk("t6_no_entry", out_valid, 0); chk("t6_count", fifo_count, 0); cyc();
    end
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
